multi_dataflow_tile_sched: RTL and testbench
============================================

Name: multi_dataflow_tile_sched

Overview:
- Sequencing controller for the multi_dataflow streamer. It launches two source streams (in1, in2) and one sink stream (out_r) once per tile, and starts the engine alongside them.
- Waits for every stream and the engine to finish, then advances the per-stream base addresses by a fixed stride.
- Repeats for a programmed number of tiles, then raises a done pulse and an event toward the HWPE controller.
- Sits between the register-file/control FSM and the streamer's ctrl_i/flags_o interface.

Parameters:
- NB_IN, 2, number of source streams
- ADDR_W, 32, address width
- CNT_W, 16, width of the tile counter and of the transfer length

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- clear_i  in  1  synchronous soft clear, same effect as rst_i
- start_i  in  1  start job (pulse); ignored unless IDLE
- n_tiles_i  in  CNT_W  tiles per job; sampled on accepted start
- tile_len_i  in  CNT_W  words per tile per stream; sampled on start
- stride_i  in  ADDR_W  byte increment per tile; sampled on start
- base_in_i  in  NB_IN*ADDR_W  source base addresses; slice k = stream k; sampled on start
- base_out_i  in  ADDR_W  sink base address; sampled on start
- src_ready_i  in  NB_IN  source ready_start flags
- src_done_i  in  NB_IN  source done pulses
- sink_ready_i  in  1  sink ready_start flag
- sink_done_i  in  1  sink done pulse
- eng_done_i  in  1  engine done pulse
- src_req_start_o  out  NB_IN  source req_start pulses
- src_addr_o  out  NB_IN*ADDR_W  current source base addresses
- sink_req_start_o  out  1  sink req_start pulse
- sink_addr_o  out  ADDR_W  current sink base address
- trans_size_o  out  CNT_W  latched tile_len
- eng_start_o  out  1  engine start pulse
- tile_idx_o  out  CNT_W  index of the current tile
- busy_o  out  1  high in any state other than IDLE
- done_o  out  1  one-cycle pulse at end of job
- evt_o  out  1  one-cycle pulse; asserted in the same cycle as done_o

Behaviour:
- Reset and clear:
  - rst_i or clear_i high at a clock edge forces state IDLE.
  - All outputs go to 0, as do the latched configuration, the counters and the sticky done flags.
  - clear_i has priority over every other input. No done_o is produced when a job is aborted.
- State machine: IDLE, LAUNCH, WAIT, ADVANCE, FINISH.
- IDLE:
  - start_i=1 latches all configuration, sets tile_idx=0 and the address registers to the base values.
  - Goes to FINISH if n_tiles_i==0, else to LAUNCH.
- LAUNCH:
  - Fires when all src_ready_i and sink_ready_i are high. In that same cycle, src_req_start_o, sink_req_start_o and eng_start_o are asserted for exactly one cycle, combinationally gated by state and ready.
  - On firing: sticky done flags clear and the FSM moves to WAIT. Otherwise it stays in LAUNCH with all pulses low.
- WAIT:
  - Sticky flags capture src_done_i[k], sink_done_i and eng_done_i; done pulses may arrive in any order or simultaneously.
  - When all NB_IN+2 flags are set, including pulses arriving in the current cycle, the FSM moves to ADVANCE.
  - Done pulses seen outside WAIT are ignored.
- ADVANCE:
  - Every address += stride, modulo 2^ADDR_W (wraps silently), and tile_idx += 1.
  - If tile_idx == n_tiles-1 before the increment, go to FINISH; else go to LAUNCH.
- FINISH: done_o=evt_o=1 for one cycle, then IDLE.
- Minimum latency:
  - start accepted at edge 0; req_start earliest in the cycle after edge 0 (state LAUNCH).
  - Inter-tile gap is at least 2 cycles (ADVANCE, then LAUNCH).
  - n_tiles=0: done_o is high in the cycle after acceptance.
- Outputs src_addr_o, sink_addr_o, trans_size_o and tile_idx_o are registered and stable from LAUNCH through WAIT of each tile.
- start_i while busy_o=1 is ignored and does not re-latch configuration.
- Counter width: n_tiles up to 2^CNT_W-1. The tile_idx increment on the final tile is not committed; tile_idx holds n_tiles-1 until IDLE, then clears.

Decomposition:
- Package multi_dataflow_package gains:
  - tile_sched_state_e, the enum of the five states
  - TILE_SCHED_CNT_W, a localparam default for CNT_W
  - tile_sched_cfg_t, a struct holding n_tiles, tile_len, stride and the base addresses
- One sub-module, multi_dataflow_addr_adv: the per-stream base-address register with load and stride-add enable, instantiated NB_IN+1 times.

Test Plan:
- Single tile: n_tiles=1, base_in={0x100,0x200}, base_out=0x300, len=16, all ready high.
  - All three req_start pulses and eng_start fire in the same cycle; eng_done, src_done and sink_done are returned.
  - Required: done_o exactly 1 cycle later than ADVANCE, tile_idx_o=0.
- Three tiles, stride=0x40: src_addr_o[0] goes 0x100, 0x140, 0x180; sink_addr_o goes 0x300, 0x340, 0x380.
  - Exactly 3 launches and one done_o.
- Backpressure: sink_ready_i low for 5 cycles in LAUNCH -> no req_start or eng_start during those cycles; the single pulse fires in the first cycle ready is high.
- Done ordering: eng_done, then src_done[1], then sink_done and src_done[0] in the same cycle -> ADVANCE on the following edge. The same set delivered all in one cycle behaves identically.
- n_tiles=0 -> done_o in the cycle after start with no req_start. Wrap case: base 0xFFFFFFF0, stride 0x20, 2 tiles -> second address 0x00000010.
- clear_i asserted during WAIT of tile 1 -> IDLE next cycle, all outputs 0, no done_o. start_i pulsed during busy -> ignored, configuration unchanged.

Source files
------------

// File: rtl/multi_dataflow_package.sv
// Shared types for the multi_dataflow streamer: tile scheduler states,
// default widths and the per-job configuration bundle.
package multi_dataflow_package;

    localparam int TILE_SCHED_NB_IN  = 2;
    localparam int TILE_SCHED_ADDR_W = 32;
    localparam int TILE_SCHED_CNT_W  = 16;

    typedef enum logic [2:0] {
        TS_IDLE,
        TS_LAUNCH,
        TS_WAIT,
        TS_ADVANCE,
        TS_FINISH
    } tile_sched_state_e;

    typedef struct packed {
        logic [TILE_SCHED_CNT_W-1:0]                   n_tiles;
        logic [TILE_SCHED_CNT_W-1:0]                   tile_len;
        logic [TILE_SCHED_ADDR_W-1:0]                  stride;
        logic [TILE_SCHED_NB_IN*TILE_SCHED_ADDR_W-1:0] base_in;
        logic [TILE_SCHED_ADDR_W-1:0]                  base_out;
    } tile_sched_cfg_t;

endpackage

// File: rtl/multi_dataflow_addr_adv.sv
// Per-stream base-address register: loads the job base address and
// steps by the tile stride, wrapping modulo 2^ADDR_W.
module multi_dataflow_addr_adv #(
    parameter int ADDR_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clear_i,
    input  logic              load_i,
    input  logic              adv_i,
    input  logic [ADDR_W-1:0] base_i,
    input  logic [ADDR_W-1:0] stride_i,
    output logic [ADDR_W-1:0] addr_o
);

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            addr_o <= '0;
        end else if (load_i) begin
            addr_o <= base_i;
        end else if (adv_i) begin
            addr_o <= addr_o + stride_i;
        end
    end

endmodule

// File: rtl/multi_dataflow_tile_sched.sv
// Tile sequencer for the multi_dataflow streamer: launches the source/sink
// streams and the engine once per tile, waits for all of them, then steps addresses.
module multi_dataflow_tile_sched
    import multi_dataflow_package::*;
#(
    parameter int NB_IN  = TILE_SCHED_NB_IN,
    parameter int ADDR_W = TILE_SCHED_ADDR_W,
    parameter int CNT_W  = TILE_SCHED_CNT_W
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    clear_i,
    input  logic                    start_i,
    input  logic [CNT_W-1:0]        n_tiles_i,
    input  logic [CNT_W-1:0]        tile_len_i,
    input  logic [ADDR_W-1:0]       stride_i,
    input  logic [NB_IN*ADDR_W-1:0] base_in_i,
    input  logic [ADDR_W-1:0]       base_out_i,
    input  logic [NB_IN-1:0]        src_ready_i,
    input  logic [NB_IN-1:0]        src_done_i,
    input  logic                    sink_ready_i,
    input  logic                    sink_done_i,
    input  logic                    eng_done_i,
    output logic [NB_IN-1:0]        src_req_start_o,
    output logic [NB_IN*ADDR_W-1:0] src_addr_o,
    output logic                    sink_req_start_o,
    output logic [ADDR_W-1:0]       sink_addr_o,
    output logic [CNT_W-1:0]        trans_size_o,
    output logic                    eng_start_o,
    output logic [CNT_W-1:0]        tile_idx_o,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    evt_o
);

    tile_sched_state_e state_q;
    tile_sched_cfg_t   start_cfg;

    logic [CNT_W-1:0]  n_tiles_q;
    logic [CNT_W-1:0]  tile_len_q;
    logic [CNT_W-1:0]  tile_idx_q;
    logic [ADDR_W-1:0] stride_q;
    logic [NB_IN-1:0]  src_done_q;
    logic              sink_done_q;
    logic              eng_done_q;
    logic              done_q;

    logic accept;
    logic fire;
    logic all_done;
    logic advance;
    logic last_tile;

    assign start_cfg = '{
        n_tiles:  n_tiles_i,
        tile_len: tile_len_i,
        stride:   stride_i,
        base_in:  base_in_i,
        base_out: base_out_i
    };

    assign accept    = (state_q == TS_IDLE) && start_i;
    assign fire      = (state_q == TS_LAUNCH) && (&src_ready_i) && sink_ready_i;
    assign advance   = (state_q == TS_ADVANCE);
    assign last_tile = (tile_idx_q == (n_tiles_q - CNT_W'(1)));

    // Done pulses landing in the same cycle count, so a tile can close without an extra wait cycle.
    assign all_done = (&(src_done_q | src_done_i)) && (sink_done_q | sink_done_i)
                      && (eng_done_q | eng_done_i);

    for (genvar k = 0; k < NB_IN; k++) begin : g_src_addr
        multi_dataflow_addr_adv #(
            .ADDR_W (ADDR_W)
        ) u_src_addr (
            .clk_i    (clk_i),
            .rst_i    (rst_i),
            .clear_i  (clear_i),
            .load_i   (accept),
            .adv_i    (advance),
            .base_i   (start_cfg.base_in[k*ADDR_W +: ADDR_W]),
            .stride_i (stride_q),
            .addr_o   (src_addr_o[k*ADDR_W +: ADDR_W])
        );
    end

    multi_dataflow_addr_adv #(
        .ADDR_W (ADDR_W)
    ) u_sink_addr (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clear_i  (clear_i),
        .load_i   (accept),
        .adv_i    (advance),
        .base_i   (start_cfg.base_out),
        .stride_i (stride_q),
        .addr_o   (sink_addr_o)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            state_q     <= TS_IDLE;
            n_tiles_q   <= '0;
            tile_len_q  <= '0;
            tile_idx_q  <= '0;
            stride_q    <= '0;
            src_done_q  <= '0;
            sink_done_q <= 1'b0;
            eng_done_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                TS_IDLE: begin
                    if (start_i) begin
                        n_tiles_q  <= start_cfg.n_tiles;
                        tile_len_q <= start_cfg.tile_len;
                        stride_q   <= start_cfg.stride;
                        tile_idx_q <= '0;
                        if (start_cfg.n_tiles == '0) begin
                            state_q <= TS_FINISH;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= TS_LAUNCH;
                        end
                    end
                end
                TS_LAUNCH: begin
                    if (fire) begin
                        src_done_q  <= '0;
                        sink_done_q <= 1'b0;
                        eng_done_q  <= 1'b0;
                        state_q     <= TS_WAIT;
                    end
                end
                TS_WAIT: begin
                    src_done_q  <= src_done_q | src_done_i;
                    sink_done_q <= sink_done_q | sink_done_i;
                    eng_done_q  <= eng_done_q | eng_done_i;
                    if (all_done) begin
                        state_q <= TS_ADVANCE;
                    end
                end
                TS_ADVANCE: begin
                    // The final tile keeps its index so tile_idx_o reads n_tiles-1 at done.
                    if (last_tile) begin
                        state_q <= TS_FINISH;
                        done_q  <= 1'b1;
                    end else begin
                        tile_idx_q <= tile_idx_q + CNT_W'(1);
                        state_q    <= TS_LAUNCH;
                    end
                end
                TS_FINISH: begin
                    tile_idx_q <= '0;
                    state_q    <= TS_IDLE;
                end
                default: begin
                    state_q <= TS_IDLE;
                end
            endcase
        end
    end

    assign src_req_start_o  = {NB_IN{fire}};
    assign sink_req_start_o = fire;
    assign eng_start_o      = fire;
    assign trans_size_o     = tile_len_q;
    assign tile_idx_o       = tile_idx_q;
    assign busy_o           = (state_q != TS_IDLE);
    assign done_o           = done_q;
    assign evt_o            = done_q;

endmodule

// File: tb/tb_multi_dataflow_tile_sched.sv
// Randomized bench for multi_dataflow_tile_sched: a job-level model predicts
// launch cycles, tile addresses and the done pulse from the scheduling rules.
module tb_multi_dataflow_tile_sched;

    localparam int NB_IN  = 2;
    localparam int ADDR_W = 32;
    localparam int CNT_W  = 16;

    localparam int PH_START  = 0;
    localparam int PH_LAUNCH = 1;
    localparam int PH_WAIT   = 2;
    localparam int PH_FINISH = 3;
    localparam int PH_END    = 4;

    localparam int JOB_CYCLE_LIMIT = 2000;

    logic                    clk_i = 1'b0;
    logic                    rst_i;
    logic                    clear_i;
    logic                    start_i;
    logic [CNT_W-1:0]        n_tiles_i;
    logic [CNT_W-1:0]        tile_len_i;
    logic [ADDR_W-1:0]       stride_i;
    logic [NB_IN*ADDR_W-1:0] base_in_i;
    logic [ADDR_W-1:0]       base_out_i;
    logic [NB_IN-1:0]        src_ready_i;
    logic [NB_IN-1:0]        src_done_i;
    logic                    sink_ready_i;
    logic                    sink_done_i;
    logic                    eng_done_i;
    logic [NB_IN-1:0]        src_req_start_o;
    logic [NB_IN*ADDR_W-1:0] src_addr_o;
    logic                    sink_req_start_o;
    logic [ADDR_W-1:0]       sink_addr_o;
    logic [CNT_W-1:0]        trans_size_o;
    logic                    eng_start_o;
    logic [CNT_W-1:0]        tile_idx_o;
    logic                    busy_o;
    logic                    done_o;
    logic                    evt_o;

    int check_count = 0;
    int fail_count  = 0;

    always #5 clk_i = ~clk_i;

    multi_dataflow_tile_sched #(
        .NB_IN  (NB_IN),
        .ADDR_W (ADDR_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .clear_i          (clear_i),
        .start_i          (start_i),
        .n_tiles_i        (n_tiles_i),
        .tile_len_i       (tile_len_i),
        .stride_i         (stride_i),
        .base_in_i        (base_in_i),
        .base_out_i       (base_out_i),
        .src_ready_i      (src_ready_i),
        .src_done_i       (src_done_i),
        .sink_ready_i     (sink_ready_i),
        .sink_done_i      (sink_done_i),
        .eng_done_i       (eng_done_i),
        .src_req_start_o  (src_req_start_o),
        .src_addr_o       (src_addr_o),
        .sink_req_start_o (sink_req_start_o),
        .sink_addr_o      (sink_addr_o),
        .trans_size_o     (trans_size_o),
        .eng_start_o      (eng_start_o),
        .tile_idx_o       (tile_idx_o),
        .busy_o           (busy_o),
        .done_o           (done_o),
        .evt_o            (evt_o)
    );

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        check_count++;
        if (observed !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // One job, cycle by cycle. done_mode: 0 random order, 1 staggered fixed order,
    // 2 all done pulses together. clear_tile >= 0 aborts during that tile's wait.
    task automatic applyStimulus(input int n_tiles, input logic [CNT_W-1:0] len,
                                 input logic [ADDR_W-1:0] stride, input logic [ADDR_W-1:0] b0,
                                 input logic [ADDR_W-1:0] b1, input logic [ADDR_W-1:0] bo,
                                 input int ready_pct, input int sink_hold,
                                 input int done_mode, input int clear_tile);
        int phase       = PH_START;
        int tile        = 0;
        int launch_from = 0;
        int done_cycle  = 0;
        int last_done   = 0;
        int clear_cyc   = -1;
        bit aborted     = 1'b0;
        bit finished    = 1'b0;
        int done_at[4];
        logic all_ready;
        logic launch_exp;
        logic [ADDR_W-1:0] exp_src0;
        logic [ADDR_W-1:0] exp_src1;
        logic [ADDR_W-1:0] exp_sink;

        for (int c = 0; c < JOB_CYCLE_LIMIT && !finished; c++) begin
            if (c == 0) begin
                start_i    = 1'b1;
                n_tiles_i  = CNT_W'(n_tiles);
                tile_len_i = len;
                stride_i   = stride;
                base_in_i  = {b1, b0};
                base_out_i = bo;
            end else begin
                start_i    = (phase != PH_END) && ($urandom_range(0, 3) == 0);
                n_tiles_i  = CNT_W'($urandom);
                tile_len_i = CNT_W'($urandom);
                stride_i   = $urandom;
                base_in_i  = {$urandom, $urandom};
                base_out_i = $urandom;
            end

            if (phase == PH_LAUNCH && c >= launch_from && c < launch_from + sink_hold) begin
                src_ready_i  = '1;
                sink_ready_i = 1'b0;
            end else begin
                for (int k = 0; k < NB_IN; k++) begin
                    src_ready_i[k] = ($urandom_range(0, 99) < ready_pct);
                end
                sink_ready_i = ($urandom_range(0, 99) < ready_pct);
            end

            if (phase == PH_WAIT) begin
                src_done_i[0] = (c == done_at[0]);
                src_done_i[1] = (c == done_at[1]);
                sink_done_i   = (c == done_at[2]);
                eng_done_i    = (c == done_at[3]);
            end else if (phase == PH_LAUNCH) begin
                src_done_i[0] = ($urandom_range(0, 7) == 0);
                src_done_i[1] = ($urandom_range(0, 7) == 0);
                sink_done_i   = ($urandom_range(0, 7) == 0);
                eng_done_i    = ($urandom_range(0, 7) == 0);
            end else begin
                src_done_i  = '0;
                sink_done_i = 1'b0;
                eng_done_i  = 1'b0;
            end
            clear_i = (c == clear_cyc);

            @(negedge clk_i);
            all_ready  = (&src_ready_i) && sink_ready_i;
            launch_exp = (phase == PH_LAUNCH) && (c >= launch_from) && all_ready;
            exp_src0   = b0 + stride * ADDR_W'(tile);
            exp_src1   = b1 + stride * ADDR_W'(tile);
            exp_sink   = bo + stride * ADDR_W'(tile);

            checkOutput("req_start", 64'({src_req_start_o, sink_req_start_o, eng_start_o}),
                        launch_exp ? 64'hF : 64'h0);
            checkOutput("done_evt", 64'({done_o, evt_o}),
                        (phase == PH_FINISH && c == done_cycle) ? 64'h3 : 64'h0);
            checkOutput("busy", 64'(busy_o), 64'((c >= 1) && (phase != PH_END)));

            if ((phase == PH_LAUNCH && c >= launch_from) || phase == PH_WAIT) begin
                checkOutput("src_addr", 64'(src_addr_o), {exp_src1, exp_src0});
                checkOutput("sink_len_idx", {sink_addr_o, trans_size_o, tile_idx_o},
                            {exp_sink, len, CNT_W'(tile)});
            end

            if (phase == PH_END) begin
                if (aborted) begin
                    checkOutput("abort_src_addr", 64'(src_addr_o), 64'h0);
                    checkOutput("abort_sink_len_idx", {sink_addr_o, trans_size_o, tile_idx_o},
                                64'h0);
                end else begin
                    checkOutput("idle_src_addr", 64'(src_addr_o),
                                {b1 + stride * ADDR_W'(n_tiles), b0 + stride * ADDR_W'(n_tiles)});
                    checkOutput("idle_sink_len_idx", {sink_addr_o, trans_size_o, tile_idx_o},
                                {bo + stride * ADDR_W'(n_tiles), len, CNT_W'(0)});
                end
                finished = 1'b1;
            end else if (phase == PH_START) begin
                if (n_tiles == 0) begin
                    phase      = PH_FINISH;
                    done_cycle = c + 1;
                end else begin
                    phase       = PH_LAUNCH;
                    launch_from = c + 1;
                end
            end else if (launch_exp) begin
                phase = PH_WAIT;
                if (done_mode == 1) begin
                    done_at[3] = c + 1;
                    done_at[1] = c + 2;
                    done_at[2] = c + 3;
                    done_at[0] = c + 3;
                end else if (done_mode == 2) begin
                    for (int j = 0; j < 4; j++) done_at[j] = c + 2;
                end else begin
                    for (int j = 0; j < 4; j++) done_at[j] = c + int'($urandom_range(1, 5));
                end
                last_done = done_at[0];
                for (int j = 1; j < 4; j++) begin
                    if (done_at[j] > last_done) last_done = done_at[j];
                end
                if (clear_tile == tile) clear_cyc = c + 1;
            end else if (phase == PH_WAIT && c == clear_cyc) begin
                phase   = PH_END;
                aborted = 1'b1;
            end else if (phase == PH_WAIT && c == last_done) begin
                tile++;
                if (tile == n_tiles) begin
                    phase      = PH_FINISH;
                    done_cycle = c + 2;
                end else begin
                    phase       = PH_LAUNCH;
                    launch_from = c + 2;
                end
            end else if (phase == PH_FINISH && c == done_cycle) begin
                phase = PH_END;
            end

            @(posedge clk_i);
            #1;
        end

        start_i     = 1'b0;
        clear_i     = 1'b0;
        src_done_i  = '0;
        sink_done_i = 1'b0;
        eng_done_i  = 1'b0;
        if (!finished) checkOutput("job_timeout", 64'h0, 64'h1);
    endtask

    initial begin
        rst_i        = 1'b1;
        clear_i      = 1'b0;
        start_i      = 1'b1;
        n_tiles_i    = 16'd3;
        tile_len_i   = 16'd7;
        stride_i     = 32'h40;
        base_in_i    = {32'h1234_0000, 32'h5678_0000};
        base_out_i   = 32'h9abc_0000;
        src_ready_i  = '1;
        sink_ready_i = 1'b1;
        src_done_i   = '1;
        sink_done_i  = 1'b1;
        eng_done_i   = 1'b1;

        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        checkOutput("reset_pulses", 64'({src_req_start_o, sink_req_start_o, eng_start_o,
                                         busy_o, done_o, evt_o}), 64'h0);
        checkOutput("reset_src_addr", 64'(src_addr_o), 64'h0);
        checkOutput("reset_sink_len_idx", {sink_addr_o, trans_size_o, tile_idx_o}, 64'h0);
        @(posedge clk_i);
        #1;
        rst_i       = 1'b0;
        start_i     = 1'b0;
        src_done_i  = '0;
        sink_done_i = 1'b0;
        eng_done_i  = 1'b0;

        applyStimulus(1, 16'd16, 32'h40, 32'h100, 32'h200, 32'h300, 100, 0, 0, -1);
        applyStimulus(3, 16'd16, 32'h40, 32'h100, 32'h200, 32'h300, 100, 0, 0, -1);
        applyStimulus(2, 16'd8, 32'h10, 32'h1000, 32'h2000, 32'h3000, 100, 5, 0, -1);
        applyStimulus(2, 16'd4, 32'h80, 32'h400, 32'h500, 32'h600, 100, 0, 1, -1);
        applyStimulus(2, 16'd4, 32'h80, 32'h400, 32'h500, 32'h600, 100, 0, 2, -1);
        applyStimulus(0, 16'd9, 32'h40, 32'h700, 32'h800, 32'h900, 100, 0, 0, -1);
        applyStimulus(2, 16'd4, 32'h20, 32'hFFFF_FFF0, 32'hFFFF_FFE0, 32'hFFFF_FFF0, 100, 0, 0, -1);
        applyStimulus(3, 16'd12, 32'h40, 32'h100, 32'h200, 32'h300, 100, 0, 0, 1);

        for (int i = 0; i < 14; i++) begin
            int nt;
            int ct;
            nt = int'($urandom_range(0, 4));
            ct = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 3)) : -1;
            applyStimulus(nt, CNT_W'($urandom), $urandom, $urandom, $urandom, $urandom,
                          int'($urandom_range(60, 100)), int'($urandom_range(0, 3)),
                          int'($urandom_range(0, 2)), ct);
        end

        $display("TB_RESULT checks=%0d failures=%0d", check_count, fail_count);
        $finish;
    end

endmodule
